// File: rtl/sdram_rd_port.sv
// sdram_rd_port
//   Single-line read buffer and burst-fill sequencer in the SDRAM_CLK domain.
//   It sits between the CPU-side word-read handshake and the SDRAM controller.
//   Reads that hit the buffered line are answered after one busy cycle. On a
//   miss it requests a burst starting at the line base, and it returns the
//   requested word on the cycle after that word arrives.
//
// Ports
//   SDRAM_CLK   in   clock, all logic on posedge
//   RESET       in   asynchronous, active-high reset
//   INVALIDATE  in   one-cycle pulse that drops the buffered line
//   RD          in   read request, sampled while RD_RDY=1
//   RADDR       in   word address of the read
//   RD_RDY      out  idle; DOUT holds the data of the last accepted read
//   DOUT        out  read data
//   MEM_REQ     out  burst request, held until MEM_ACK
//   MEM_ADDR    out  line base address of the burst
//   MEM_ACK     in   controller took the request
//   MEM_DVALID  in   one burst word on MEM_DIN
//   MEM_DIN     in   burst data, in order from the line base
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | no burst outstanding; hits are served from the line buffer
// REQ   | MEM_REQ held high, waiting for MEM_ACK
// FILL  | burst words arriving; buffer and valid bits filled in order
module sdram_rd_port #(
  parameter int ADDR_W     = 25,
  parameter int LINE_WORDS = 4
) (
  input  logic              SDRAM_CLK,
  input  logic              RESET,
  input  logic              INVALIDATE,
  input  logic              RD,
  input  logic [ADDR_W-1:0] RADDR,
  output logic              RD_RDY,
  output logic [15:0]       DOUT,
  output logic              MEM_REQ,
  output logic [ADDR_W-1:0] MEM_ADDR,
  input  logic              MEM_ACK,
  input  logic              MEM_DVALID,
  input  logic [15:0]       MEM_DIN
);

  localparam int IDX_W = $clog2(LINE_WORDS);
  localparam int TAG_W = ADDR_W - IDX_W;

  typedef enum logic [1:0] {IDLE, REQ, FILL} state_t;

  state_t                  state;
  state_t                  state_nxt;

  logic [TAG_W-1:0]        tag;
  logic [LINE_WORDS-1:0]   valid;
  logic [15:0]             line_buf [LINE_WORDS];
  logic [IDX_W-1:0]        cnt;

  // A read waiting for its word to arrive in the current burst.
  logic                    wait_word;
  logic [IDX_W-1:0]        req_idx;

  // A hit accepted last cycle; its data moves to DOUT this cycle.
  logic                    hit_pend;
  logic [IDX_W-1:0]        hit_idx;

  // A read for another line, accepted during FILL, replayed as a miss at fill end.
  logic                    pending;
  logic [ADDR_W-1:0]       pend_addr;

  // INVALIDATE seen during FILL; the line is dropped once the burst finishes.
  logic                    inv_pend;

  logic                    rd_rdy;
  logic [15:0]             dout;
  logic                    mem_req;
  logic [ADDR_W-1:0]       mem_addr;

  logic                    accept;
  logic                    fill_wr;
  logic                    fill_last;
  logic                    inv_eff;
  logic                    line_ok;
  logic                    hit;
  logic [LINE_WORDS-1:0]   wr_mask;
  logic [LINE_WORDS-1:0]   valid_upd;
  logic [TAG_W-1:0]        rd_tag;
  logic [IDX_W-1:0]        rd_idx;

  logic                    do_hit;
  logic                    do_wait;
  logic                    do_pend;
  logic                    do_miss;
  logic [ADDR_W-1:0]       miss_addr;

  assign RD_RDY   = rd_rdy;
  assign DOUT     = dout;
  assign MEM_REQ  = mem_req;
  assign MEM_ADDR = mem_addr;

  assign rd_tag    = RADDR[ADDR_W-1:IDX_W];
  assign rd_idx    = RADDR[IDX_W-1:0];
  assign accept    = RD & rd_rdy;
  assign fill_wr   = (state == FILL) & MEM_DVALID;
  assign fill_last = fill_wr & (cnt == IDX_W'(LINE_WORDS - 1));
  assign inv_eff   = inv_pend | INVALIDATE;

  // The word written this cycle already counts as valid for a read accepted
  // on the same edge.
  assign wr_mask   = fill_wr ? (LINE_WORDS'(1) << cnt) : '0;
  assign valid_upd = valid | wr_mask;

  // A line marked for invalidation is never reused, even for words that
  // already arrived.
  assign line_ok = (rd_tag == tag) & ~INVALIDATE & ~inv_pend;
  assign hit     = line_ok & valid_upd[rd_idx];

  always_ff @(posedge SDRAM_CLK or posedge RESET) begin
    if (RESET) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    do_hit    = 1'b0;
    do_wait   = 1'b0;
    do_pend   = 1'b0;
    do_miss   = 1'b0;
    miss_addr = RADDR;
    case (state)
      IDLE: begin
        if (accept) begin
          if (hit) begin
            do_hit = 1'b1;
          end else begin
            do_miss = 1'b1;
          end
        end
      end
      REQ: begin
        if (MEM_ACK) begin
          state_nxt = FILL;
        end
      end
      FILL: begin
        if (fill_last) begin
          state_nxt = IDLE;
        end
        if (accept) begin
          if (hit) begin
            do_hit = 1'b1;
          end else if (line_ok) begin
            do_wait = 1'b1;
          end else if (fill_last) begin
            // The fill ends on this edge, so the other-line read goes straight out.
            do_miss = 1'b1;
          end else begin
            do_pend = 1'b1;
          end
        end else if (fill_last && pending) begin
          do_miss   = 1'b1;
          miss_addr = pend_addr;
        end
      end
      default: state_nxt = IDLE;
    endcase
    if (do_miss) begin
      state_nxt = REQ;
    end
  end

  // Buffer data carries no reset; the valid bits guard every read of it.
  always_ff @(posedge SDRAM_CLK) begin
    if (fill_wr) begin
      line_buf[cnt] <= MEM_DIN;
    end
  end

  always_ff @(posedge SDRAM_CLK or posedge RESET) begin
    if (RESET) begin
      tag       <= '0;
      valid     <= '0;
      cnt       <= '0;
      wait_word <= 1'b0;
      req_idx   <= '0;
      hit_pend  <= 1'b0;
      hit_idx   <= '0;
      pending   <= 1'b0;
      pend_addr <= '0;
      inv_pend  <= 1'b0;
      rd_rdy    <= 1'b1;
      dout      <= '0;
      mem_req   <= 1'b0;
      mem_addr  <= '0;
    end else begin
      if (fill_wr) begin
        cnt <= cnt + IDX_W'(1);
      end

      if (do_miss) begin
        valid <= '0;
      end else if (fill_last && inv_eff) begin
        valid <= '0;
      end else if (INVALIDATE && state != FILL) begin
        valid <= '0;
      end else begin
        valid <= valid_upd;
      end

      if (do_miss || fill_last) begin
        inv_pend <= 1'b0;
      end else if (state == FILL && INVALIDATE) begin
        inv_pend <= 1'b1;
      end

      if (state == REQ && MEM_ACK) begin
        mem_req <= 1'b0;
        cnt     <= '0;
      end

      if (fill_wr && wait_word && cnt == req_idx) begin
        dout      <= MEM_DIN;
        rd_rdy    <= 1'b1;
        wait_word <= 1'b0;
      end

      if (hit_pend) begin
        dout     <= line_buf[hit_idx];
        rd_rdy   <= 1'b1;
        hit_pend <= 1'b0;
      end

      if (do_hit) begin
        rd_rdy   <= 1'b0;
        hit_pend <= 1'b1;
        hit_idx  <= rd_idx;
      end

      if (do_wait) begin
        rd_rdy    <= 1'b0;
        wait_word <= 1'b1;
        req_idx   <= rd_idx;
      end

      if (do_pend) begin
        rd_rdy    <= 1'b0;
        pending   <= 1'b1;
        pend_addr <= RADDR;
      end

      if (do_miss) begin
        tag       <= miss_addr[ADDR_W-1:IDX_W];
        mem_addr  <= {miss_addr[ADDR_W-1:IDX_W], {IDX_W{1'b0}}};
        mem_req   <= 1'b1;
        wait_word <= 1'b1;
        req_idx   <= miss_addr[IDX_W-1:0];
        rd_rdy    <= 1'b0;
        pending   <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_sdram_rd_port.sv
// tb_sdram_rd_port
//   Directed bench for sdram_rd_port with a scoreboard of expected read data.
//   Burst data is a function of a generation nibble and the word address, so a
//   refetch after INVALIDATE returns different data than the stale line.
module tb_sdram_rd_port;

  logic        sdram_clk;
  logic        reset;
  logic        invalidate;
  logic        rd;
  logic [24:0] raddr;
  logic        rd_rdy;
  logic [15:0] dout;
  logic        mem_req;
  logic [24:0] mem_addr;
  logic        mem_ack;
  logic        mem_dvalid;
  logic [15:0] mem_din;

  int          tests;
  int          fails;
  logic [3:0]  gen;
  logic [15:0] exp_q [$];

  sdram_rd_port #(.ADDR_W(25), .LINE_WORDS(4)) dut (
    .SDRAM_CLK  (sdram_clk),
    .RESET      (reset),
    .INVALIDATE (invalidate),
    .RD         (rd),
    .RADDR      (raddr),
    .RD_RDY     (rd_rdy),
    .DOUT       (dout),
    .MEM_REQ    (mem_req),
    .MEM_ADDR   (mem_addr),
    .MEM_ACK    (mem_ack),
    .MEM_DVALID (mem_dvalid),
    .MEM_DIN    (mem_din)
  );

  initial sdram_clk = 1'b0;
  always #5 sdram_clk = ~sdram_clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [15:0] word_of(input logic [24:0] a);
    return {gen, a[11:0]};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Present a read for one edge; it must be accepted and RD_RDY must drop.
  task automatic issue_rd(input logic [24:0] a, input logic exp_req, input string tag);
    rd    = 1'b1;
    raddr = a;
    exp_q.push_back(word_of(a));
    @(negedge sdram_clk);
    rd         = 1'b0;
    mem_dvalid = 1'b0;
    invalidate = 1'b0;
    check({tag, "_acc"}, 32'(rd_rdy), 32'd0);
    check({tag, "_req"}, 32'(mem_req), 32'(exp_req));
    if (exp_req) begin
      check({tag, "_addr"}, 32'(mem_addr), 32'({a[24:2], 2'b00}));
    end
  endtask

  // Wait (bounded) for RD_RDY, check the latency and pop the expected data.
  task automatic wait_ret(input int budget, input string tag, input int exp_cyc);
    int n;
    logic [15:0] e;
    n = 0;
    while (rd_rdy !== 1'b1 && n < budget) begin
      @(negedge sdram_clk);
      n++;
    end
    check({tag, "_rdy"}, 32'(rd_rdy), 32'd1);
    check({tag, "_lat"}, 32'(n), 32'(exp_cyc));
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      check({tag, "_dout"}, 32'(dout), 32'(e));
    end else begin
      tests++;
      fails++;
      $error("FAIL %s_dout observed=%0h expected=none queued", tag, dout);
    end
  endtask

  task automatic ack();
    mem_ack = 1'b1;
    @(negedge sdram_clk);
    mem_ack = 1'b0;
    check("ack_req_drop", 32'(mem_req), 32'd0);
  endtask

  task automatic send_w(input logic [24:0] base, input int i);
    mem_dvalid = 1'b1;
    mem_din    = word_of(base + 25'(i));
    @(negedge sdram_clk);
    mem_dvalid = 1'b0;
  endtask

  initial begin
    tests      = 0;
    fails      = 0;
    gen        = 4'hA;
    reset      = 1'b1;
    invalidate = 1'b0;
    rd         = 1'b0;
    raddr      = '0;
    mem_ack    = 1'b0;
    mem_dvalid = 1'b0;
    mem_din    = '0;
    repeat (3) @(negedge sdram_clk);
    reset = 1'b0;
    check("rst_rdy",  32'(rd_rdy),   32'd1);
    check("rst_dout", 32'(dout),     32'd0);
    check("rst_req",  32'(mem_req),  32'd0);
    check("rst_addr", 32'(mem_addr), 32'd0);

    // Miss at 0x12: burst from 0x10, data returned after the third word.
    issue_rd(25'h12, 1'b1, "t1");
    @(negedge sdram_clk);
    check("t1_hold", 32'(mem_req), 32'd1);
    ack();
    send_w(25'h10, 0);
    check("t1_w0", 32'(rd_rdy), 32'd0);
    send_w(25'h10, 1);
    check("t1_w1", 32'(rd_rdy), 32'd0);
    send_w(25'h10, 2);
    wait_ret(2, "t1", 0);
    send_w(25'h10, 3);
    check("t1_end_req", 32'(mem_req), 32'd0);

    // Hits on the buffered line, including its last word.
    issue_rd(25'h11, 1'b0, "t2");
    wait_ret(3, "t2", 1);
    issue_rd(25'h13, 1'b0, "t2b");
    wait_ret(3, "t2b", 1);
    check("t2_noreq", 32'(mem_req), 32'd0);

    // Reads during FILL: early return, DVALID coincident with a hit, and a
    // read that waits for a word still in flight.
    issue_rd(25'h30, 1'b1, "t3");
    ack();
    send_w(25'h30, 0);
    wait_ret(2, "t3", 0);
    mem_dvalid = 1'b1;
    mem_din    = word_of(25'h31);
    issue_rd(25'h31, 1'b0, "t3hit");
    wait_ret(3, "t3hit", 1);
    issue_rd(25'h33, 1'b0, "t3wait");
    send_w(25'h30, 2);
    check("t3_w2", 32'(rd_rdy), 32'd0);
    send_w(25'h30, 3);
    wait_ret(2, "t3wait", 0);

    // Other-line read during FILL is held until the burst ends.
    issue_rd(25'h41, 1'b1, "t4");
    ack();
    send_w(25'h40, 0);
    check("t4_w0", 32'(rd_rdy), 32'd0);
    send_w(25'h40, 1);
    wait_ret(2, "t4", 0);
    issue_rd(25'h22, 1'b0, "t4pend");
    send_w(25'h40, 2);
    check("t4_w2_noreq", 32'(mem_req), 32'd0);
    send_w(25'h40, 3);
    check("t4_req",  32'(mem_req),  32'd1);
    check("t4_addr", 32'(mem_addr), 32'h20);
    check("t4_busy", 32'(rd_rdy),   32'd0);
    ack();
    send_w(25'h20, 0);
    send_w(25'h20, 1);
    send_w(25'h20, 2);
    wait_ret(2, "t4pend", 0);
    send_w(25'h20, 3);

    // INVALIDATE in IDLE, during FILL, and coincident with a hit.
    issue_rd(25'h21, 1'b0, "t5hit");
    wait_ret(3, "t5hit", 1);
    gen        = 4'hB;
    invalidate = 1'b1;
    @(negedge sdram_clk);
    invalidate = 1'b0;
    issue_rd(25'h22, 1'b1, "t5inv");
    ack();
    invalidate = 1'b1;
    send_w(25'h20, 0);
    invalidate = 1'b0;
    send_w(25'h20, 1);
    check("t5_w1", 32'(rd_rdy), 32'd0);
    send_w(25'h20, 2);
    wait_ret(2, "t5inv", 0);
    send_w(25'h20, 3);
    issue_rd(25'h21, 1'b1, "t5after");
    ack();
    send_w(25'h20, 0);
    send_w(25'h20, 1);
    wait_ret(2, "t5after", 0);
    send_w(25'h20, 2);
    send_w(25'h20, 3);
    invalidate = 1'b1;
    issue_rd(25'h23, 1'b1, "t5coinc");
    ack();
    send_w(25'h20, 0);
    send_w(25'h20, 1);
    send_w(25'h20, 2);
    send_w(25'h20, 3);
    wait_ret(2, "t5coinc", 0);

    // Reset mid-burst: outputs drop asynchronously, stale words are ignored.
    issue_rd(25'h53, 1'b1, "t6");
    ack();
    send_w(25'h50, 0);
    send_w(25'h50, 1);
    reset = 1'b1;
    #1;
    check("t6_rst_rdy",  32'(rd_rdy),   32'd1);
    check("t6_rst_dout", 32'(dout),     32'd0);
    check("t6_rst_req",  32'(mem_req),  32'd0);
    check("t6_rst_addr", 32'(mem_addr), 32'd0);
    exp_q.delete();
    @(negedge sdram_clk);
    reset = 1'b0;
    send_w(25'h50, 2);
    send_w(25'h50, 3);
    check("t6_stale_rdy",  32'(rd_rdy),  32'd1);
    check("t6_stale_dout", 32'(dout),    32'd0);
    check("t6_stale_req",  32'(mem_req), 32'd0);
    issue_rd(25'h12, 1'b1, "t6re");
    ack();
    send_w(25'h10, 0);
    send_w(25'h10, 1);
    send_w(25'h10, 2);
    wait_ret(2, "t6re", 0);
    send_w(25'h10, 3);
    issue_rd(25'h11, 1'b0, "t6hit");
    wait_ret(3, "t6hit", 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
